// File: rtl/serial_adder_n.sv
// serial_adder_n: digit-serial adder computing s = a + b + cin over WIDTH bits,
// DIGIT bits per clock, with a start/busy/done handshake. One DIGIT-bit adder
// slice plus a carry flip-flop is reused for every digit, LSB digit first.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder_n: DIGIT=%0d must be in 1..WIDTH and divide WIDTH=%0d",
           DIGIT, WIDTH);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

  // Operand copies are shifted right one digit per RUN cycle, so the digit
  // being added is always in the low DIGIT bits. The accumulator fills from
  // the top and ends up in natural order after NDIG shifts.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_shift;

  // Digit slice: add the current low digits plus carry; shift the new digit into acc.
  always_comb begin
    dsum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
    acc_shift = WIDTH'({dsum[DIGIT-1:0], acc_q} >> DIGIT);
  end

  // Next-state and datapath control for the IDLE/RUN/DONE sequence.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          acc_d   = '0;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = dsum[DIGIT];
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          s_d     = acc_shift;
          cout_d  = dsum[DIGIT];
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers; synchronous reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  // Operand and accumulator storage.
  always_ff @(posedge clk) begin
    // NOTE: no reset here: these are loaded on every accepted start before being read, so their reset value is never visible.
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

  // Handshake outputs are pure decodes of the state register.
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign s    = s_q;
  assign cout = cout_q;

endmodule
